// File: rtl/me_msad_if.sv
// PSAD beat stream and minimum-SAD result handshake between the engine and its neighbours.
// The engine uses the slave view; the PSAD producer / result consumer uses the master view.
interface me_msad_if #(
    parameter int CANDS          = 16,
    parameter int PSAD_BIT_WIDTH = 11,
    parameter int SAD_BIT_WIDTH  = 14,
    parameter int IDX_W          = 5
);
    logic                            psad_valid;
    logic                            psad_ready;
    logic [CANDS*PSAD_BIT_WIDTH-1:0] psad_in;
    logic                            msad_valid;
    logic                            msad_ready;
    logic [SAD_BIT_WIDTH-1:0]        msad;
    logic [IDX_W-1:0]                msad_col;
    logic [IDX_W-1:0]                msad_row;
    logic                            early_term;

    modport slave (
        input  psad_valid, psad_in, msad_ready,
        output psad_ready, msad_valid, msad, msad_col, msad_row, early_term
    );

    modport master (
        output psad_valid, psad_in, msad_ready,
        input  psad_ready, msad_valid, msad, msad_col, msad_row, early_term
    );
endinterface

// File: rtl/me_msad_engine.sv
// SAD accumulation and minimum search for block motion estimation: sums EDGE_LEN PSAD
// beats per candidate batch, reduces each batch, and tracks the global minimum and position.
module me_msad_engine #(
    parameter int CANDS          = 16,
    parameter int EDGE_LEN       = 8,
    parameter int PSAD_BIT_WIDTH = 11,
    parameter int SAD_BIT_WIDTH  = 14,
    parameter int COL_BATCHES    = 1,
    parameter int SEARCH_ROWS    = 16,
    parameter int IDX_W          = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     early_en,
    input  logic [SAD_BIT_WIDTH-1:0] threshold,
    output logic                     busy,
    me_msad_if.slave                 bus
);
    localparam int CIDX_W = $clog2(CANDS);
    localparam int BCNT_W = $clog2(EDGE_LEN) + 1;
    localparam int SUM_W  = SAD_BIT_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REDUCE, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [SAD_BIT_WIDTH-1:0] r_acc [CANDS];
    logic [BCNT_W-1:0]        r_beat_cnt;
    logic [IDX_W-1:0]         r_batch_col, r_batch_row;
    logic                     r_first, r_early_en;
    logic [SAD_BIT_WIDTH-1:0] r_thr;
    logic [SAD_BIT_WIDTH-1:0] r_msad;
    logic [IDX_W-1:0]         r_msad_col, r_msad_row;
    logic                     r_early_term;

    logic                     w_start_acc, w_beat, w_last_beat, w_last_batch;
    logic [SAD_BIT_WIDTH-1:0] w_bmin, w_upd_min;
    logic [CIDX_W-1:0]        w_bidx;
    logic [IDX_W-1:0]         w_col;
    logic                     w_take, w_term_early;

    // Zero-extended add that clamps at all-ones instead of wrapping.
    function automatic logic [SAD_BIT_WIDTH-1:0] sat_add(
        input logic [SAD_BIT_WIDTH-1:0]  a,
        input logic [PSAD_BIT_WIDTH-1:0] b
    );
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[SAD_BIT_WIDTH] ? '1 : s[SAD_BIT_WIDTH-1:0];
    endfunction

    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_beat       = (r_state == S_ACCUM) && bus.psad_valid;
    assign w_last_beat  = w_beat && (r_beat_cnt == BCNT_W'(EDGE_LEN - 1));
    assign w_last_batch = (r_batch_row == IDX_W'(SEARCH_ROWS - 1)) &&
                          (r_batch_col == IDX_W'(COL_BATCHES - 1));

    // Strict less-than keeps the lowest candidate index on ties.
    always_comb begin
        w_bmin = r_acc[0];
        w_bidx = '0;
        for (int c = 1; c < CANDS; c++) begin
            if (r_acc[c] < w_bmin) begin
                w_bmin = r_acc[c];
                w_bidx = CIDX_W'(c);
            end
        end
    end

    // Earlier batches keep the running minimum on ties.
    assign w_take    = r_first || (w_bmin < r_msad);
    assign w_upd_min = w_take ? w_bmin : r_msad;
    assign w_col     = IDX_W'(int'(r_batch_col) * CANDS) + IDX_W'(w_bidx);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_term_early = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ACCUM;
            S_ACCUM:  if (w_last_beat) w_next = S_REDUCE;
            S_REDUCE: begin
                if (w_last_batch) begin
                    w_next = S_DONE;
                end else if (r_early_en && (w_upd_min <= r_thr)) begin
                    w_next       = S_DONE;
                    w_term_early = 1'b1;
                end else begin
                    w_next = S_ACCUM;
                end
            end
            S_DONE:   if (bus.msad_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CANDS; c++) r_acc[c] <= '0;
            r_beat_cnt   <= '0;
            r_batch_col  <= '0;
            r_batch_row  <= '0;
            r_first      <= 1'b0;
            r_early_en   <= 1'b0;
            r_thr        <= '0;
            r_msad       <= '0;
            r_msad_col   <= '0;
            r_msad_row   <= '0;
            r_early_term <= 1'b0;
        end else if (w_start_acc) begin
            for (int c = 0; c < CANDS; c++) r_acc[c] <= '0;
            r_beat_cnt  <= '0;
            r_batch_col <= '0;
            r_batch_row <= '0;
            r_first     <= 1'b1;
            r_early_en  <= early_en;
            r_thr       <= threshold;
        end else if (w_beat) begin
            for (int c = 0; c < CANDS; c++)
                r_acc[c] <= sat_add(r_acc[c], bus.psad_in[c*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end else if (r_state == S_REDUCE) begin
            if (w_take) begin
                r_msad     <= w_bmin;
                r_msad_col <= w_col;
                r_msad_row <= r_batch_row;
            end
            r_first      <= 1'b0;
            r_early_term <= w_term_early;
            for (int c = 0; c < CANDS; c++) r_acc[c] <= '0;
            r_beat_cnt <= '0;
            if (r_batch_col == IDX_W'(COL_BATCHES - 1)) begin
                r_batch_col <= '0;
                r_batch_row <= r_batch_row + 1'b1;
            end else begin
                r_batch_col <= r_batch_col + 1'b1;
            end
        end
    end

    assign bus.psad_ready = (r_state == S_ACCUM);
    assign bus.msad_valid = (r_state == S_DONE);
    assign bus.msad       = r_msad;
    assign bus.msad_col   = r_msad_col;
    assign bus.msad_row   = r_msad_row;
    assign bus.early_term = r_early_term;
    assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_me_msad_engine.sv
// Directed bench for me_msad_engine: a default-parameter instance and a narrow-SAD,
// two-column-batch instance share the PSAD stream; only the started one consumes it.
module tb_me_msad_engine;
    logic          clk;
    logic          rst;
    logic          start_a, start_b;
    logic          early_en;
    logic [13:0]   threshold;
    logic          psad_valid;
    logic [175:0]  psad_in;
    logic          msad_ready;
    logic          busy_a, busy_b;
    bit            sel;
    int            checks;
    int            errors;

    me_msad_if #(.CANDS(16), .PSAD_BIT_WIDTH(11), .SAD_BIT_WIDTH(14), .IDX_W(5)) bus_a ();
    me_msad_if #(.CANDS(16), .PSAD_BIT_WIDTH(11), .SAD_BIT_WIDTH(12), .IDX_W(5)) bus_b ();

    assign bus_a.psad_valid = psad_valid;
    assign bus_a.psad_in    = psad_in;
    assign bus_a.msad_ready = msad_ready;
    assign bus_b.psad_valid = psad_valid;
    assign bus_b.psad_in    = psad_in;
    assign bus_b.msad_ready = msad_ready;

    me_msad_engine dut_a (
        .clk(clk), .rst(rst), .start(start_a), .early_en(early_en),
        .threshold(threshold), .busy(busy_a), .bus(bus_a)
    );

    me_msad_engine #(
        .CANDS(16), .EDGE_LEN(8), .PSAD_BIT_WIDTH(11), .SAD_BIT_WIDTH(12),
        .COL_BATCHES(2), .SEARCH_ROWS(4), .IDX_W(5)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .early_en(early_en),
        .threshold(threshold[11:0]), .busy(busy_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] pat(input int scn, input int row, input int col, input int beat);
        case (scn)
            1: return (row == 9 && col == 5) ? 11'd3 : 11'd100;
            2: return 11'd7;
            3: return ((row == 4 || row == 6) && (col == 3 || col == 11)) ? 11'd2 : 11'd7;
            4: return (row == 2 && col == 7) ? ((beat == 0) ? 11'd12 : 11'd4) : 11'd10;
            5: return 11'd2047;
            6: return (row == 3 && col == 21) ? 11'd20 : 11'd100;
            default: return 11'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit b, input bit en, input int thr);
        early_en  = en;
        threshold = 14'(thr);
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        tick();
        start_a   = 1'b0;
        start_b   = 1'b0;
        early_en  = 1'b0;
        threshold = '0;
    endtask

    // Offers beats in row/batch/beat order until a result appears, max_beats are taken, or the budget expires.
    task automatic feed(input int scn, input int max_beats, input bit gaps,
                        output int cycles, output int accepted, output bit timeout);
        int  row, bcol, beat, colb;
        bit  v, take, rdy, mv;
        row = 0; bcol = 0; beat = 0; cycles = 0; accepted = 0;
        colb = sel ? 2 : 1;
        mv = sel ? bus_b.msad_valid : bus_a.msad_valid;
        while (!mv && accepted < max_beats && cycles < 3000) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            psad_valid = v;
            for (int c = 0; c < 16; c++) psad_in[c*11 +: 11] = pat(scn, row, bcol*16 + c, beat);
            rdy  = sel ? bus_b.psad_ready : bus_a.psad_ready;
            take = v && rdy;
            tick();
            cycles++;
            if (take) begin
                accepted++;
                beat++;
                if (beat == 8) begin
                    beat = 0;
                    bcol++;
                    if (bcol == colb) begin
                        bcol = 0;
                        row++;
                    end
                end
            end
            mv = sel ? bus_b.msad_valid : bus_a.msad_valid;
        end
        psad_valid = 1'b0;
        timeout = !mv && accepted < max_beats;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_a.psad_ready, bus_a.msad_valid, busy_a, bus_a.early_term} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl_a: got %b expected 0000",
                {bus_a.psad_ready, bus_a.msad_valid, busy_a, bus_a.early_term});
        end
        checks++;
        if ({bus_a.msad, bus_a.msad_col, bus_a.msad_row} !== 24'd0) begin
            errors++; $display("FAIL reset_data_a: got msad %0d col %0d row %0d expected 0 0 0",
                bus_a.msad, bus_a.msad_col, bus_a.msad_row);
        end
        checks++;
        if ({bus_b.psad_ready, bus_b.msad_valid, busy_b, bus_b.msad, bus_b.msad_col, bus_b.msad_row} !== 25'd0) begin
            errors++; $display("FAIL reset_b: got rdy %b vld %b busy %b msad %0d expected all 0",
                bus_b.psad_ready, bus_b.msad_valid, busy_b, bus_b.msad);
        end
    endtask

    task automatic test_single_min();
        int cyc, acc; bit to;
        sel = 0;
        do_start(0, 0, 0);
        checks++;
        if (bus_a.psad_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready_after_start: got %b expected 1", bus_a.psad_ready);
        end
        feed(1, 100000, 0, cyc, acc, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: got no msad_valid expected result"); end
        checks++;
        if (cyc != 144) begin errors++; $display("FAIL single_latency: got %0d cycles expected 144", cyc); end
        checks++;
        if (bus_a.msad !== 14'd24 || bus_a.msad_col !== 5'd5 || bus_a.msad_row !== 5'd9 || bus_a.early_term !== 1'b0) begin
            errors++; $display("FAIL single_result: got msad %0d col %0d row %0d et %b expected 24 5 9 0",
                bus_a.msad, bus_a.msad_col, bus_a.msad_row, bus_a.early_term);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || bus_a.msad_valid !== 1'b0) begin
            errors++; $display("FAIL single_release: got busy %b valid %b expected 0 0", busy_a, bus_a.msad_valid);
        end
    endtask

    task automatic test_ties();
        int cyc, acc; bit to;
        sel = 0;
        do_start(0, 0, 0);
        feed(2, 100000, 0, cyc, acc, to);
        checks++;
        if (to || bus_a.msad !== 14'd56 || bus_a.msad_col !== 5'd0 || bus_a.msad_row !== 5'd0) begin
            errors++; $display("FAIL ties_flat: got msad %0d col %0d row %0d timeout %b expected 56 0 0 0",
                bus_a.msad, bus_a.msad_col, bus_a.msad_row, to);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
        do_start(0, 0, 0);
        feed(3, 100000, 0, cyc, acc, to);
        checks++;
        if (to || bus_a.msad !== 14'd16 || bus_a.msad_col !== 5'd3 || bus_a.msad_row !== 5'd4) begin
            errors++; $display("FAIL ties_lowest: got msad %0d col %0d row %0d timeout %b expected 16 3 4 0",
                bus_a.msad, bus_a.msad_col, bus_a.msad_row, to);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
    endtask

    task automatic test_early_term();
        int cyc, acc; bit to;
        sel = 0;
        do_start(0, 1, 40);
        feed(4, 100000, 0, cyc, acc, to);
        checks++;
        if (to || cyc != 27) begin
            errors++; $display("FAIL early_latency: got %0d cycles timeout %b expected 27 0", cyc, to);
        end
        checks++;
        if (bus_a.msad !== 14'd40 || bus_a.msad_col !== 5'd7 || bus_a.msad_row !== 5'd2 || bus_a.early_term !== 1'b1) begin
            errors++; $display("FAIL early_result: got msad %0d col %0d row %0d et %b expected 40 7 2 1",
                bus_a.msad, bus_a.msad_col, bus_a.msad_row, bus_a.early_term);
        end
        psad_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_a.psad_ready !== 1'b0 || bus_a.msad_valid !== 1'b1) begin
                errors++; $display("FAIL early_hold: got ready %b valid %b expected 0 1", bus_a.psad_ready, bus_a.msad_valid);
            end
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
        tick();
        checks++;
        if (bus_a.psad_ready !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL early_idle: got ready %b busy %b expected 0 0", bus_a.psad_ready, busy_a);
        end
        psad_valid = 1'b0;
        do_start(0, 1, 39);
        feed(4, 100000, 0, cyc, acc, to);
        checks++;
        if (to || cyc != 144 || bus_a.msad !== 14'd40 || bus_a.msad_col !== 5'd7 ||
            bus_a.msad_row !== 5'd2 || bus_a.early_term !== 1'b0) begin
            errors++; $display("FAIL early_below_thr: got cyc %0d msad %0d col %0d row %0d et %b expected 144 40 7 2 0",
                cyc, bus_a.msad, bus_a.msad_col, bus_a.msad_row, bus_a.early_term);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
    endtask

    task automatic test_saturation();
        int cyc, acc; bit to;
        sel = 1;
        do_start(1, 0, 0);
        feed(5, 100000, 0, cyc, acc, to);
        checks++;
        if (to || cyc != 72) begin
            errors++; $display("FAIL sat_latency: got %0d cycles timeout %b expected 72 0", cyc, to);
        end
        checks++;
        if (bus_b.msad !== 12'd4095 || bus_b.msad_col !== 5'd0 || bus_b.msad_row !== 5'd0) begin
            errors++; $display("FAIL sat_result: got msad %0d col %0d row %0d expected 4095 0 0",
                bus_b.msad, bus_b.msad_col, bus_b.msad_row);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, acc; bit to;
        sel = 1;
        do_start(1, 0, 0);
        feed(6, 100000, 1, cyc, acc, to);
        checks++;
        if (to || acc != 64) begin
            errors++; $display("FAIL bp_beats: got %0d beats timeout %b expected 64 0", acc, to);
        end
        for (int i = 0; i < 10; i++) begin
            start_b = (i == 4);
            tick();
            checks++;
            if (bus_b.msad_valid !== 1'b1 || bus_b.msad !== 12'd160 ||
                bus_b.msad_col !== 5'd21 || bus_b.msad_row !== 5'd3) begin
                errors++; $display("FAIL bp_stall: got valid %b msad %0d col %0d row %0d expected 1 160 21 3",
                    bus_b.msad_valid, bus_b.msad, bus_b.msad_col, bus_b.msad_row);
            end
        end
        msad_ready = 1'b1; start_b = 1'b1;
        tick();
        msad_ready = 1'b0; start_b = 1'b0;
        checks++;
        if (busy_b !== 1'b0 || bus_b.msad_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got busy %b valid %b expected 0 0", busy_b, bus_b.msad_valid);
        end
        tick();
        checks++;
        if (busy_b !== 1'b0 || bus_b.psad_ready !== 1'b0) begin
            errors++; $display("FAIL bp_start_ignored: got busy %b ready %b expected 0 0", busy_b, bus_b.psad_ready);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, acc; bit to;
        sel = 0;
        do_start(0, 0, 0);
        feed(2, 50, 0, cyc, acc, to);
        checks++;
        if (acc != 50) begin errors++; $display("FAIL rstmid_beats: got %0d beats expected 50", acc); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({bus_a.psad_ready, bus_a.msad_valid, busy_a, bus_a.early_term} !== 4'b0 ||
            {bus_a.msad, bus_a.msad_col, bus_a.msad_row} !== 24'd0) begin
            errors++; $display("FAIL rstmid_outputs: got rdy %b vld %b busy %b msad %0d col %0d row %0d expected all 0",
                bus_a.psad_ready, bus_a.msad_valid, busy_a, bus_a.msad, bus_a.msad_col, bus_a.msad_row);
        end
        do_start(0, 0, 0);
        feed(3, 100000, 0, cyc, acc, to);
        checks++;
        if (to || cyc != 144 || bus_a.msad !== 14'd16 || bus_a.msad_col !== 5'd3 || bus_a.msad_row !== 5'd4) begin
            errors++; $display("FAIL rstmid_new: got cyc %0d msad %0d col %0d row %0d expected 144 16 3 4",
                cyc, bus_a.msad, bus_a.msad_col, bus_a.msad_row);
        end
        msad_ready = 1'b1; tick(); msad_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; early_en = 1'b0; threshold = '0;
        psad_valid = 1'b0; psad_in = '0; msad_ready = 1'b0;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single_min();
        test_ties();
        test_early_term();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
